spi_slave_ram_burst: RTL and testbench
======================================

Name: spi_slave_ram_burst

Overview:
Parametrised next-generation SPI slave with an embedded single-port RAM. It supports configurable address and data widths, and burst read/write with optional address auto-increment while SS_n stays low. The SPI interface is sampled directly in the system clock domain, and MISO returns RAM data MSB first. The block sits at the chip pin boundary as a memory-mapped configuration and data store.

Parameters:
ADDR_WIDTH, 8, address bits; MEM_DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 8, word width in bits
AUTO_INC, 1, 1 = pointer increments after each burst word; 0 = pointer held

Ports:
clk  input  1  system clock; all sampling and driving on rising edge
rst  input  1  synchronous, active-high reset
SS_n  input  1  slave select, active low; frame delimiter
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first
busy  output  1  high while a frame is in progress

Behaviour:
- Reset is synchronous and active-high: on a rising edge with rst=1, all state is cleared.
  - MISO=0, busy=0, state=IDLE, wr_ptr=0, rd_ptr=0, shift and bit counters 0.
  - RAM contents are retained, not cleared.
  - rst has priority over all other inputs.
- Frame start: in IDLE, the first rising edge with SS_n=0 samples MOSI as opcode bit 1 (MSB). busy=1 from this edge.
  - The next edge samples opcode bit 0.
  - SS_n=1 at any edge returns the block to IDLE; busy=0 and MISO=0 from that edge.
- Opcodes (2 bits):
  - 00 WR_ADDR: next ADDR_WIDTH bits load wr_ptr on the edge sampling the LSB. Further bits are ignored (state WAIT_END) until SS_n=1.
  - 01 WR_DATA: each DATA_WIDTH-bit word is written to mem[wr_ptr] on the edge after its LSB is sampled.
    - In the same cycle, wr_ptr += AUTO_INC (mod MEM_DEPTH).
    - The next word's MSB is sampled on that same edge, so there is no gap between words.
  - 10 RD_ADDR: next ADDR_WIDTH bits load rd_ptr; then WAIT_END.
  - 11 RD_DATA: MOSI is ignored after the opcode.
    - RAM read of mem[rd_ptr] is issued on the edge after opcode LSB.
    - One turnaround cycle follows (MISO=0).
    - The word MSB is driven on MISO from the 2nd edge after opcode LSB, one bit per cycle.
    - The next word (rd_ptr += AUTO_INC) is prefetched during the shift, so its MSB follows the previous LSB with no gap.
- States: IDLE, OPCODE, ADDR_SHIFT, WDATA_SHIFT, RD_TURN, RDATA_SHIFT, WAIT_END.
- Pointers wrap from MEM_DEPTH-1 to 0. wr_ptr and rd_ptr are independent and persist across frames.
- Abort (SS_n=1 mid-word):
  - A partial address does not update its pointer.
  - A partial WR_DATA word is discarded; completed burst words are kept.
  - A partial read word is truncated, but rd_ptr still reflects the words already prefetched/advanced.
- A new frame requires at least one edge with SS_n=1 between frames.
- The RAM port is shared. A write frame never reads and a read frame never writes, so there are no port conflicts.
- A reset asserted mid-operation takes effect on that edge; no RAM write occurs on the reset edge.

Decomposition:
- Package spi_ram_pkg: opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11; state enum/localparams.
- Sub-module spi_ram_sp: parametrised single-port RAM (ADDR_WIDTH, DATA_WIDTH).
  - Ports: clk, en, we, addr, din, dout.
  - Synchronous read with 1-cycle latency; write does not update dout.

Test Plan:
- Reset with rst=1 for 4 cycles while SS_n=0, MOSI=1 -> MISO=0, busy=0 throughout and one edge after release with SS_n=1; wr_ptr=rd_ptr=0.
- Basic write/read sequence -> MISO shifts 1,0,1,0,0,1,0,1 starting at the 2nd edge after opcode LSB; busy drops on the edge SS_n=1 is sampled.
  - Frames: WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA for 8 bits.
- Wrap-around burst:
  - WR_ADDR 0xFE, then one WR_DATA frame 0x11,0x22,0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33.
  - RD_ADDR 0xFE, then RD_DATA for 24 bits -> MISO stream 0x11,0x22,0x33 contiguous.
- Abort: preload mem[0x10]=0x77; WR_ADDR 0x10, then WR_DATA with SS_n raised after 5 payload bits -> read of 0x10 returns 0x77 and wr_ptr remains 0x10.
- Reset mid-read: during an RD_DATA burst, assert rst on bit 3 of word 2 -> MISO=0 and busy=0 from that edge; a following RD_DATA frame reads from address 0.
- AUTO_INC=0 instance: WR_ADDR 0x05, WR_DATA burst 0x01,0x02 -> mem[0x05]=0x02, mem[0x06] unchanged.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcode and FSM state definitions for the SPI RAM slave.
`timescale 1ns/1ps
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ADDR_SHIFT,
    WDATA_SHIFT,
    RD_TURN,
    RDATA_SHIFT,
    WAIT_END
  } state_t;

endpackage

// File: rtl/spi_ram_sp.sv
// Single-port RAM, synchronous read with one cycle latency; writes leave dout untouched.
`timescale 1ns/1ps
module spi_ram_sp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are never reset so configuration survives a controller reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_slave_ram_burst.sv
// SPI slave sampled in the system clock domain, fronting a single-port RAM
// with burst access and optional pointer auto-increment.
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | no frame; waiting for SS_n low (samples opcode MSB)
// OPCODE      | sampling opcode LSB
// ADDR_SHIFT  | shifting address into wr_ptr or rd_ptr
// WDATA_SHIFT | shifting write words, each committed one edge later
// RD_TURN     | first RAM read in flight, MISO held low
// RDATA_SHIFT | shifting read words out, next word prefetched
// WAIT_END    | extra bits ignored until SS_n high
`timescale 1ns/1ps
module spi_slave_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy
);

  localparam int SHW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW  = $clog2(SHW + 1);

  state_t                state, state_nx;
  logic [SHW-1:0]        shreg, shin, dout_ext;
  logic [CW-1:0]         bit_cnt;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, ram_addr;
  logic [DATA_WIDTH-1:0] wdata, ram_dout;
  logic                  wr_pend, rd_issue, ram_en, ram_we;

  assign shin     = (shreg << 1) | SHW'(MOSI);
  assign dout_ext = SHW'(ram_dout);

  // State register; SS_n high ends any frame through the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    if (SS_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:        state_nx = OPCODE;
        OPCODE: begin
          case (shin[1:0])
            OP_WR_DATA: state_nx = WDATA_SHIFT;
            OP_RD_DATA: state_nx = RD_TURN;
            default:    state_nx = ADDR_SHIFT;
          endcase
        end
        ADDR_SHIFT:  if (bit_cnt == '0) state_nx = WAIT_END;
        RD_TURN:     state_nx = RDATA_SHIFT;
        default:     state_nx = state;
      endcase
    end
  end

  // RAM port control and status. A completed write word commits on the edge
  // after its LSB even if SS_n rises there; reads only advance while selected.
  always_comb begin
    busy     = (state != IDLE);
    ram_we   = wr_pend & ~rst;
    rd_issue = ~SS_n & ((state == RD_TURN) ||
                        ((state == RDATA_SHIFT) && (bit_cnt == CW'(DATA_WIDTH-1))));
    ram_en   = ram_we | rd_issue;
    ram_addr = wr_pend ? wr_ptr : rd_ptr;
  end

  // Shift, bit-count, pointer and MISO datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      MISO    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      op_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wdata   <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend)  wr_ptr <= wr_ptr + ADDR_WIDTH'(AUTO_INC);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(AUTO_INC);
      if (SS_n) begin
        MISO    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            MISO  <= 1'b0;
            shreg <= shin;
          end
          OPCODE: begin
            MISO <= 1'b0;
            op_q <= shin[1:0];
            if (shin[1:0] == OP_WR_DATA)      bit_cnt <= CW'(DATA_WIDTH-1);
            else if (shin[1:0] == OP_RD_DATA) bit_cnt <= '0;
            else                              bit_cnt <= CW'(ADDR_WIDTH-1);
          end
          ADDR_SHIFT: begin
            shreg <= shin;
            if (bit_cnt == '0) begin
              if (op_q == OP_WR_ADDR) wr_ptr <= shin[ADDR_WIDTH-1:0];
              else                    rd_ptr <= shin[ADDR_WIDTH-1:0];
            end else begin
              bit_cnt <= bit_cnt - CW'(1);
            end
          end
          WDATA_SHIFT: begin
            shreg <= shin;
            if (bit_cnt == '0) begin
              wdata   <= shin[DATA_WIDTH-1:0];
              wr_pend <= 1'b1;
              bit_cnt <= CW'(DATA_WIDTH-1);
            end else begin
              bit_cnt <= bit_cnt - CW'(1);
            end
          end
          RD_TURN: begin
            MISO    <= 1'b0;
            bit_cnt <= '0;
          end
          RDATA_SHIFT: begin
            // Terminal count reloads from the prefetched RAM word.
            if (bit_cnt == '0) begin
              MISO    <= ram_dout[DATA_WIDTH-1];
              shreg   <= dout_ext << 1;
              bit_cnt <= CW'(DATA_WIDTH-1);
            end else begin
              MISO    <= shreg[DATA_WIDTH-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - CW'(1);
            end
          end
          default: MISO <= 1'b0;
        endcase
      end
    end
  end

  spi_ram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .din (wdata),
    .dout(ram_dout)
  );

endmodule

// File: tb/tb_spi_slave_ram_burst.sv
// Directed bench: one auto-increment and one pointer-hold instance share the SPI bus.
`timescale 1ns/1ps
module tb_spi_slave_ram_burst;

  logic clk = 1'b0;
  logic rst, ss_n, mosi;
  logic miso0, busy0, miso1, busy1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spi_slave_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) u_dut_inc (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso0), .busy(busy0)
  );

  spi_slave_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(0)) u_dut_hold (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ss_n = 1'b0;
    mosi = b;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  task automatic addr_frame(input logic [1:0] op, input logic [7:0] a);
    send_bits({30'd0, op}, 2);
    send_bits({24'd0, a}, 8);
    end_frame();
  endtask

  task automatic wr_frame(input logic [31:0] words, input int nw);
    send_bits(32'h1, 2);
    for (int w = nw - 1; w >= 0; w--) send_bits(words >> (8 * w), 8);
    end_frame();
  endtask

  task automatic rd_frame(input string tag, input int nw,
                          input logic [31:0] exp0, input logic [31:0] exp1);
    logic [31:0] rx0, rx1;
    rx0 = '0;
    rx1 = '0;
    send_bits(32'h3, 2);
    chk({tag, "_busy_in_frame"}, {31'd0, busy0}, 32'd1);
    send_bit(1'b1);
    chk({tag, "_turnaround_miso"}, {30'd0, miso1, miso0}, 32'd0);
    for (int i = 0; i < 8 * nw; i++) begin
      send_bit(1'b1);
      rx0 = {rx0[30:0], miso0};
      rx1 = {rx1[30:0], miso1};
    end
    end_frame();
    chk({tag, "_end_busy_miso"}, {28'd0, busy1, miso1, busy0, miso0}, 32'd0);
    chk({tag, "_data_inc"}, rx0, exp0);
    chk({tag, "_data_hold"}, rx1, exp1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] part;
    rst  = 1'b1;
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();

    // Reset held with an active-looking bus
    ss_n = 1'b0;
    mosi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_hold_outputs", {28'd0, busy1, miso1, busy0, miso0}, 32'd0);
    end
    rst  = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    chk("reset_release_outputs", {28'd0, busy1, miso1, busy0, miso0}, 32'd0);

    // Both pointers start at zero: unaddressed write then read hits mem[0]
    wr_frame(32'h5A, 1);
    rd_frame("ptr_zero", 1, 32'h5A, 32'h5A);

    // Basic write/read: 0xA5 streams 1,0,1,0,0,1,0,1
    addr_frame(2'b00, 8'h3C);
    wr_frame(32'hA5, 1);
    addr_frame(2'b10, 8'h3C);
    rd_frame("basic", 1, 32'hA5, 32'hA5);

    // Wrap-around burst; hold instance rewrites 0xFE each word
    addr_frame(2'b00, 8'hFE);
    wr_frame(32'h112233, 3);
    addr_frame(2'b10, 8'hFE);
    rd_frame("wrap", 3, 32'h112233, 32'h333333);

    // Abort mid-word: preload 0x77, abort 5 bits into 0x99
    addr_frame(2'b00, 8'h10);
    wr_frame(32'h77, 1);
    addr_frame(2'b00, 8'h10);
    send_bits(32'h1, 2);
    send_bits(32'b10011, 5);
    end_frame();
    addr_frame(2'b10, 8'h10);
    rd_frame("abort_kept", 1, 32'h77, 32'h77);
    wr_frame(32'h99, 1);
    addr_frame(2'b10, 8'h10);
    rd_frame("abort_wrptr", 1, 32'h99, 32'h99);

    // Reset on bit 3 of word 2 of a burst from 0xFE
    addr_frame(2'b10, 8'hFE);
    send_bits(32'h3, 2);
    send_bit(1'b0);
    part = '0;
    for (int i = 0; i < 11; i++) begin
      send_bit(1'b0);
      part = {part[30:0], miso0};
    end
    chk("midrd_partial", part, 32'h089);
    rst = 1'b1;
    send_bit(1'b0);
    chk("midrd_reset_outputs", {28'd0, busy1, miso1, busy0, miso0}, 32'd0);
    rst = 1'b0;
    end_frame();
    rd_frame("after_reset", 1, 32'h33, 32'h5A);

    // Pointer hold versus increment on a two-word burst
    addr_frame(2'b00, 8'h06);
    wr_frame(32'hC3, 1);
    addr_frame(2'b00, 8'h05);
    wr_frame(32'h0102, 2);
    addr_frame(2'b10, 8'h05);
    rd_frame("hold_a5", 2, 32'h0102, 32'h0202);
    addr_frame(2'b10, 8'h06);
    rd_frame("hold_a6", 1, 32'h02, 32'hC3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
